seq_ctrl: RTL and testbench
===========================

Name: seq_ctrl

Overview:
Parametrised successor to the CPU's five-state control sequencer (IDLE/OPCFT/OPLFT/EXE/LOAD).
- Adds a configurable number of operand-fetch words and a memory-ready handshake on the fetch states.
- Adds a single-step mode, a LOAD-state timeout with a sticky error flag, and a retire pulse.
- Sits between the front panel (run/hlt/step) and the datapath, which decodes q or the one-hot strobes.

Parameters:
NOPL, 1, operand-fetch words per instruction; legal 1..8.
TMO, 16, maximum consecutive LOAD cycles with kp high; 0 disables the timeout.
OCW, 3, width of opcnt; must satisfy 2**OCW >= NOPL.
TCW, 5, width of the timeout counter; must satisfy 2**TCW >= TMO.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  start request, sampled in IDLE
hlt  in  1  halt request, sampled in EXE only
kp  in  1  keep/load pending; high means the load is not yet complete
step  in  1  single-step mode; level, sampled at instruction end
mrdy  in  1  memory ready; a fetch state completes only when mrdy=1
q  out  3  state: IDLE=0, OPCFT=1, OPLFT=2, EXE=3, LOAD=4
opcnt  out  OCW  index of the operand word currently being fetched
s_opc, s_opl, s_exe, s_ld  out  1  one-hot decodes of q (OPCFT, OPLFT, EXE, LOAD)
retire  out  1  one-cycle pulse when an instruction completes
err  out  1  sticky LOAD-timeout flag
busy  out  1  high whenever q != IDLE

Behaviour:
Reset (rst_n=0, asynchronous):
- q=IDLE, opcnt=0, timeout counter=0, err=0, retire=0.
- All strobes follow q, so all are 0 and busy=0.

State and counter updates:
- q, opcnt, the timeout counter, err and retire are registers updated on the rising clk edge.
- Strobes and busy are combinational decodes of the q register.

Transitions:
- IDLE: run=1 -> OPCFT, and err is cleared on the same edge. Otherwise hold.
- OPCFT: mrdy=1 -> OPLFT with opcnt=0. mrdy=0 -> hold (wait state).
- OPLFT:
  - mrdy=0 -> hold, opcnt unchanged.
  - mrdy=1 and opcnt<NOPL-1 -> stay in OPLFT, opcnt+1.
  - mrdy=1 and opcnt==NOPL-1 -> EXE, opcnt=0.
  - NOPL=1 therefore gives exactly one OPLFT cycle when mrdy=1.
- EXE, priority order:
  1. hlt=1 -> IDLE.
  2. kp=1 -> LOAD, timeout counter=0.
  3. Otherwise the instruction ends: step=1 -> IDLE, step=0 -> OPCFT.
- LOAD:
  - kp=0 -> instruction ends: step=1 -> IDLE, step=0 -> OPCFT.
  - kp=1 and TMO!=0 and counter==TMO-1 -> IDLE, err=1.
  - kp=1 otherwise -> hold, counter+1.
  - Net effect: LOAD is occupied for at most TMO cycles.
- Any unused encoding (5..7) -> IDLE on the next edge. Never X.

retire:
- Registered pulse, high for the one cycle after an instruction ends normally.
- Normal end means: EXE with hlt=0 and kp=0, or LOAD with kp=0.
- Not asserted on hlt or on timeout.

Boundary conditions:
- hlt and kp both high in EXE: hlt wins.
- hlt is ignored in every state other than EXE.
- step is sampled only at the instruction-end edge. Changing it mid-instruction has no effect until that edge.
- mrdy is don't-care in IDLE, EXE and LOAD.
- err stays set until the next accepted run. A timeout while err is already 1 keeps it at 1.
- Reset asserted mid-instruction returns to the reset state immediately, without waiting for clk.

Latency:
- Minimum instruction with mrdy=1 and kp=0 is 1 OPCFT + NOPL OPLFT + 1 EXE = NOPL+2 cycles.

Test Plan:
1. NOPL=3, TMO=16. Pulse run, hold mrdy=1, kp=0, step=0 -> q sequence 1,2,2,2,3,1,…; opcnt 0,1,2 across the OPLFT cycles; retire pulses every 5 cycles.
2. Drop mrdy for 2 cycles in OPCFT and for 1 cycle during the second OPLFT word -> q holds in that state, opcnt does not advance, instruction takes 8 cycles.
3. Assert kp in EXE for 4 cycles, then drop it -> 4 LOAD cycles, then OPCFT; retire pulses once; err=0.
4. TMO=16, kp held high -> exactly 16 LOAD cycles, then IDLE with err=1 and no retire; next run clears err.
5. step=1 with NOPL=1 -> run, then OPCFT, OPLFT, EXE, then IDLE with busy=0; the second run repeats. hlt and kp high together in EXE -> IDLE, not LOAD.
6. Assert rst_n=0 asynchronously mid-OPLFT at opcnt=2 -> q=0, opcnt=0, err=0 before the next clk edge. Force q=6 -> IDLE after one edge.

Source files
------------

// File: rtl/seq_ctrl_if.sv
// Signal bundle between the front panel / datapath and the seq_ctrl sequencer.
// The master drives the requests and handshakes, and the slave (the sequencer) drives state and strobes.
interface seq_ctrl_if #(
   parameter int OCW = 3
);
   logic           run;
   logic           hlt;
   logic           kp;
   logic           step;
   logic           mrdy;
   logic [2:0]     q;
   logic [OCW-1:0] opcnt;
   logic           s_opc;
   logic           s_opl;
   logic           s_exe;
   logic           s_ld;
   logic           retire;
   logic           err;
   logic           busy;

   modport master (
      output run, hlt, kp, step, mrdy,
      input  q, opcnt, s_opc, s_opl, s_exe, s_ld, retire, err, busy
   );

   modport slave (
      input  run, hlt, kp, step, mrdy,
      output q, opcnt, s_opc, s_opl, s_exe, s_ld, retire, err, busy
   );
endinterface

// File: rtl/seq_ctrl.sv
// Five-state CPU control sequencer (IDLE/OPCFT/OPLFT/EXE/LOAD) with multi-word operand fetch,
// a memory-ready wait handshake, single-step mode, a LOAD timeout with a sticky error flag, and a retire pulse.
module seq_ctrl #(
   parameter int NOPL = 1,
   parameter int TMO  = 16,
   parameter int OCW  = 3,
   parameter int TCW  = 5
) (
   input logic       clk,
   input logic       rst_n,
   seq_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      OPCFT = 3'd1,
      OPLFT = 3'd2,
      EXE   = 3'd3,
      LOAD  = 3'd4
   } state_t;

   // The state register is a plain vector so that encodings 5..7 stay representable and recover to IDLE.
   logic [2:0]     q_r;
   logic [OCW-1:0] opcnt_r;
   logic [TCW-1:0] tcnt_r;
   logic           err_r;
   logic           retire_r;
   logic           opl_last;
   logic           tmo_hit;

   assign opl_last = (opcnt_r == OCW'(NOPL - 1));
   assign tmo_hit  = (TMO != 0) && (tcnt_r == TCW'(TMO - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_r      <= IDLE;
         opcnt_r  <= '0;
         tcnt_r   <= '0;
         err_r    <= 1'b0;
         retire_r <= 1'b0;
      end else begin
         retire_r <= 1'b0;
         case (q_r)
            IDLE: begin
               if (bus.run) begin
                  q_r   <= OPCFT;
                  err_r <= 1'b0;
               end
            end
            OPCFT: begin
               if (bus.mrdy) begin
                  q_r     <= OPLFT;
                  opcnt_r <= '0;
               end
            end
            OPLFT: begin
               if (bus.mrdy) begin
                  if (opl_last) begin
                     q_r     <= EXE;
                     opcnt_r <= '0;
                  end else begin
                     opcnt_r <= opcnt_r + OCW'(1);
                  end
               end
            end
            EXE: begin
               if (bus.hlt) begin
                  q_r <= IDLE;
               end else if (bus.kp) begin
                  q_r    <= LOAD;
                  tcnt_r <= '0;
               end else begin
                  q_r      <= bus.step ? IDLE : OPCFT;
                  retire_r <= 1'b1;
               end
            end
            LOAD: begin
               // A timeout abandons the instruction, so it raises err but never retire.
               if (!bus.kp) begin
                  q_r      <= bus.step ? IDLE : OPCFT;
                  retire_r <= 1'b1;
               end else if (tmo_hit) begin
                  q_r   <= IDLE;
                  err_r <= 1'b1;
               end else begin
                  tcnt_r <= tcnt_r + TCW'(1);
               end
            end
            default: q_r <= IDLE;
         endcase
      end
   end

   assign bus.q      = q_r;
   assign bus.opcnt  = opcnt_r;
   assign bus.s_opc  = (q_r == OPCFT);
   assign bus.s_opl  = (q_r == OPLFT);
   assign bus.s_exe  = (q_r == EXE);
   assign bus.s_ld   = (q_r == LOAD);
   assign bus.busy   = (q_r != IDLE);
   assign bus.retire = retire_r;
   assign bus.err    = err_r;

endmodule

// File: tb/tb_seq_ctrl.sv
// Bench for seq_ctrl: a NOPL=3/TMO=16 instance driven from a vector table, plus a NOPL=1/TMO=0 instance
// and hand-written async-reset and illegal-state sequences.
module tb_seq_ctrl;
   localparam int OCW = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seq_ctrl_if #(.OCW(OCW)) b0 ();
   seq_ctrl_if #(.OCW(OCW)) b1 ();

   seq_ctrl #(.NOPL(3), .TMO(16), .OCW(3), .TCW(5)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   seq_ctrl #(.NOPL(1), .TMO(0),  .OCW(3), .TCW(5)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

   typedef struct {
      logic       run, hlt, kp, step, mrdy;
      logic [2:0] q;
      logic [2:0] opcnt;
      logic       retire, err;
   } vec_t;

   typedef struct {
      logic [2:0] q;
      logic [2:0] opcnt;
      logic       retire, err;
   } exp_t;

   vec_t vecs0[$];
   vec_t vecs1[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   ncyc   = 0;

   function automatic vec_t mk(input logic run, hlt, kp, step, mrdy,
                               input logic [2:0] q, input logic [2:0] op,
                               input logic ret, er);
      vec_t v;
      v.run = run; v.hlt = hlt; v.kp = kp; v.step = step; v.mrdy = mrdy;
      v.q = q; v.opcnt = op; v.retire = ret; v.err = er;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, req);
      end
   endtask

   task automatic drive(input int d, input vec_t v);
      if (d == 0) begin
         b0.run = v.run; b0.hlt = v.hlt; b0.kp = v.kp; b0.step = v.step; b0.mrdy = v.mrdy;
      end else begin
         b1.run = v.run; b1.hlt = v.hlt; b1.kp = v.kp; b1.step = v.step; b1.mrdy = v.mrdy;
      end
   endtask

   // One clock: drive inputs, queue the expected post-edge state, sample after the edge and compare.
   task automatic cyc(input int d, input vec_t v);
      exp_t       e;
      exp_t       pe;
      logic [2:0] aq, aop;
      logic [3:0] astb;
      logic       aret, aerr, abusy;
      string      tag;
      drive(d, v);
      pe.q = v.q; pe.opcnt = v.opcnt; pe.retire = v.retire; pe.err = v.err;
      sb.push_back(pe);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      ncyc++;
      if (d == 0) begin
         aq = b0.q; aop = b0.opcnt; aret = b0.retire; aerr = b0.err; abusy = b0.busy;
         astb = {b0.s_opc, b0.s_opl, b0.s_exe, b0.s_ld};
      end else begin
         aq = b1.q; aop = b1.opcnt; aret = b1.retire; aerr = b1.err; abusy = b1.busy;
         astb = {b1.s_opc, b1.s_opl, b1.s_exe, b1.s_ld};
      end
      tag = $sformatf("dut%0d cyc%0d", d, ncyc);
      chk({tag, " q"}, 32'(aq), 32'(e.q));
      chk({tag, " opcnt"}, 32'(aop), 32'(e.opcnt));
      chk({tag, " retire"}, 32'(aret), 32'(e.retire));
      chk({tag, " err"}, 32'(aerr), 32'(e.err));
      chk({tag, " busy"}, 32'(abusy), 32'(e.q != 3'd0));
      chk({tag, " strobes"}, 32'(astb),
          32'({e.q == 3'd1, e.q == 3'd2, e.q == 3'd3, e.q == 3'd4}));
   endtask

   initial begin
      // Inputs: run,hlt,kp,step,mrdy ; expected after edge: q,opcnt,retire,err.
      // Streaming with mrdy=1: retire every NOPL+2 = 5 cycles.
      vecs0.push_back(mk(1,0,0,0,1, 1,0,0,0));
      for (int r = 0; r < 2; r++) begin
         if (r == 1) vecs0.push_back(mk(0,0,0,0,1, 2,0,0,0));
         else        vecs0.push_back(mk(0,0,0,0,1, 2,0,0,0));
         vecs0.push_back(mk(0,0,0,0,1, 2,1,0,0));
         vecs0.push_back(mk(0,0,0,0,1, 2,2,0,0));
         vecs0.push_back(mk(0,0,0,0,1, 3,0,0,0));
         vecs0.push_back(mk(0,0,0,0,1, 1,0,1,0));
      end
      // mrdy wait states: 2 in OPCFT, 1 on the second operand word; hlt/kp ignored there.
      vecs0.push_back(mk(0,1,0,0,0, 1,0,0,0));
      vecs0.push_back(mk(0,0,0,0,0, 1,0,0,0));
      vecs0.push_back(mk(0,0,0,0,1, 2,0,0,0));
      vecs0.push_back(mk(0,0,0,0,1, 2,1,0,0));
      vecs0.push_back(mk(0,1,1,0,0, 2,1,0,0));
      vecs0.push_back(mk(0,0,0,0,1, 2,2,0,0));
      vecs0.push_back(mk(0,0,0,0,1, 3,0,0,0));
      vecs0.push_back(mk(0,0,0,0,0, 1,0,1,0));
      // Four LOAD cycles, then back to OPCFT with one retire; step/hlt mid-LOAD have no effect.
      vecs0.push_back(mk(0,0,0,0,1, 2,0,0,0));
      vecs0.push_back(mk(0,0,0,0,1, 2,1,0,0));
      vecs0.push_back(mk(0,0,0,0,1, 2,2,0,0));
      vecs0.push_back(mk(0,0,0,0,1, 3,0,0,0));
      vecs0.push_back(mk(0,0,1,0,0, 4,0,0,0));
      vecs0.push_back(mk(0,0,1,1,0, 4,0,0,0));
      vecs0.push_back(mk(0,1,1,0,0, 4,0,0,0));
      vecs0.push_back(mk(0,0,1,0,0, 4,0,0,0));
      vecs0.push_back(mk(0,0,0,0,0, 1,0,1,0));
      // Timeout: exactly 16 LOAD cycles, then IDLE with err and no retire.
      vecs0.push_back(mk(0,0,0,0,1, 2,0,0,0));
      vecs0.push_back(mk(0,0,0,0,1, 2,1,0,0));
      vecs0.push_back(mk(0,0,0,0,1, 2,2,0,0));
      vecs0.push_back(mk(0,0,0,0,1, 3,0,0,0));
      vecs0.push_back(mk(0,0,1,0,0, 4,0,0,0));
      for (int i = 0; i < 15; i++) vecs0.push_back(mk(0,0,1,0,0, 4,0,0,0));
      vecs0.push_back(mk(0,0,1,0,0, 0,0,0,1));
      vecs0.push_back(mk(0,1,1,0,1, 0,0,0,1));
      vecs0.push_back(mk(1,0,0,0,0, 1,0,0,0));
      // hlt and kp together in EXE: hlt wins, no retire.
      vecs0.push_back(mk(0,0,0,0,1, 2,0,0,0));
      vecs0.push_back(mk(0,0,0,0,1, 2,1,0,0));
      vecs0.push_back(mk(0,0,0,0,1, 2,2,0,0));
      vecs0.push_back(mk(0,0,0,0,1, 3,0,0,0));
      vecs0.push_back(mk(0,1,1,0,0, 0,0,0,0));
      // Single step on the 3-word instance ends in IDLE with retire.
      vecs0.push_back(mk(1,0,0,0,1, 1,0,0,0));
      vecs0.push_back(mk(0,0,0,0,1, 2,0,0,0));
      vecs0.push_back(mk(0,0,0,0,1, 2,1,0,0));
      vecs0.push_back(mk(0,0,0,0,1, 2,2,0,0));
      vecs0.push_back(mk(0,0,0,0,1, 3,0,0,0));
      vecs0.push_back(mk(0,0,0,1,0, 0,0,1,0));
      vecs0.push_back(mk(0,0,0,1,0, 0,0,0,0));

      // NOPL=1, TMO=0 instance: step mode twice, hlt+kp, then an unbounded LOAD.
      for (int r = 0; r < 2; r++) begin
         vecs1.push_back(mk(1,0,0,1,1, 1,0,0,0));
         vecs1.push_back(mk(0,0,0,1,1, 2,0,0,0));
         vecs1.push_back(mk(0,0,0,1,1, 3,0,0,0));
         vecs1.push_back(mk(0,0,0,1,1, 0,0,1,0));
         vecs1.push_back(mk(0,0,0,1,1, 0,0,0,0));
      end
      vecs1.push_back(mk(1,0,0,0,1, 1,0,0,0));
      vecs1.push_back(mk(0,0,0,0,1, 2,0,0,0));
      vecs1.push_back(mk(0,0,0,0,1, 3,0,0,0));
      vecs1.push_back(mk(0,1,1,0,1, 0,0,0,0));
      vecs1.push_back(mk(1,0,0,0,1, 1,0,0,0));
      vecs1.push_back(mk(0,0,0,0,1, 2,0,0,0));
      vecs1.push_back(mk(0,0,0,0,1, 3,0,0,0));
      vecs1.push_back(mk(0,0,1,0,0, 4,0,0,0));
      for (int i = 0; i < 40; i++) vecs1.push_back(mk(0,0,1,0,0, 4,0,0,0));
      vecs1.push_back(mk(0,0,0,0,0, 1,0,1,0));
      vecs1.push_back(mk(0,1,0,0,1, 2,0,0,0));
      vecs1.push_back(mk(0,0,0,0,1, 3,0,0,0));
      vecs1.push_back(mk(0,1,0,0,1, 0,0,0,0));

      drive(0, mk(0,0,0,0,0, 0,0,0,0));
      drive(1, mk(0,0,0,0,0, 0,0,0,0));

      // Reset state.
      #12;
      chk("reset q", 32'(b0.q), 32'd0);
      chk("reset opcnt", 32'(b0.opcnt), 32'd0);
      chk("reset retire", 32'(b0.retire), 32'd0);
      chk("reset err", 32'(b0.err), 32'd0);
      chk("reset busy", 32'(b0.busy), 32'd0);
      chk("reset strobes", 32'({b0.s_opc, b0.s_opl, b0.s_exe, b0.s_ld}), 32'd0);
      chk("reset dut1 q", 32'(b1.q), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < vecs0.size(); i++) cyc(0, vecs0[i]);
      drive(0, mk(0,0,0,0,0, 0,0,0,0));
      for (int i = 0; i < vecs1.size(); i++) cyc(1, vecs1[i]);

      // Asynchronous reset mid-OPLFT at opcnt=2 takes effect before the next edge.
      cyc(0, mk(1,0,0,0,1, 1,0,0,0));
      cyc(0, mk(0,0,0,0,1, 2,0,0,0));
      cyc(0, mk(0,0,0,0,1, 2,1,0,0));
      cyc(0, mk(0,0,0,0,1, 2,2,0,0));
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst q", 32'(b0.q), 32'd0);
      chk("async rst opcnt", 32'(b0.opcnt), 32'd0);
      chk("async rst err", 32'(b0.err), 32'd0);
      chk("async rst busy", 32'(b0.busy), 32'd0);
      drive(0, mk(0,0,0,0,0, 0,0,0,0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Illegal encoding recovers to IDLE after one edge.
      force dut0.q_r = 3'd6;
      #1;
      release dut0.q_r;
      chk("illegal busy", 32'(b0.busy), 32'd1);
      chk("illegal strobes", 32'({b0.s_opc, b0.s_opl, b0.s_exe, b0.s_ld}), 32'd0);
      cyc(0, mk(0,0,0,0,1, 0,0,0,0));

      chk("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
